shift_seq_ctrl: RTL and testbench

Command sequencer sitting directly upstream of the 8-bit bidirectional shift register. It accepts one command per valid/ready handshake, then drives the register's `ctrl`/`data` inputs. Each command is one parallel load followed by N shift steps in a chosen direction, and completion is signalled with a one-cycle `done` pulse. An optional shadow model checks the register's `q_reg` against the expected result.

---
 rtl/shift_seq_pkg.sv | 20 ++
 rtl/shift_seq_shadow.sv | 55 +++++
 rtl/shift_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared state encoding, shift-register control codes and default width for the
// shift_seq_ctrl command sequencer.
package shift_seq_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef logic [1:0] state_t;

   // Sequencer states, kept as plain constants for legacy tool flows.
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_LOAD  = 2'd1;
   localparam state_t ST_SHIFT = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   localparam logic [1:0] CTRL_HOLD = 2'b00;
   localparam logic [1:0] CTRL_SHL  = 2'b01;
   localparam logic [1:0] CTRL_SHR  = 2'b10;
   localparam logic [1:0] CTRL_LOAD = 2'b11;

endpackage

// File: rtl/shift_seq_shadow.sv
// Shadow copy of the downstream shift register plus end-of-command comparator.
// Compiled only when SHIFT_SEQ_SHADOW_EN is defined.
`ifdef SHIFT_SEQ_SHADOW_EN
module shift_seq_shadow
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       ctrl,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] q_reg,
   input  logic             chk,
   input  logic             clr,
   output logic             mismatch
);

   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             mismatch_q, mismatch_d;

   // Follows exactly the control the real register sees on each edge.
   always_comb begin
      shadow_d = shadow_q;
      case (ctrl)
         CTRL_SHL:  shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
         CTRL_SHR:  shadow_d = {1'b0, shadow_q[WIDTH-1:1]};
         CTRL_LOAD: shadow_d = data;
         default:   shadow_d = shadow_q;
      endcase
   end

   always_comb begin
      mismatch_d = mismatch_q;
      if (clr)
         mismatch_d = 1'b0;
      else if (chk && (q_reg != shadow_q))
         mismatch_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      shadow_q <= shadow_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         mismatch_q <= 1'b0;
      else
         mismatch_q <= mismatch_d;
   end

   assign mismatch = mismatch_q;

endmodule
`endif

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving an 8-bit bidirectional shift register: one load then N shifts.
// Define SHIFT_SEQ_SHADOW_EN to add the shadow check that drives mismatch.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_count,
   output logic [1:0]       ctrl,
   output logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] q_reg,
   output logic             busy,
   output logic             done,
   output logic             mismatch
);

   state_t           state_q, state_d;
   logic [1:0]       ctrl_q, ctrl_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept;

   function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
      if (int'(c) > WIDTH)
         sat_count = CNT_W'(WIDTH);
      else
         sat_count = c;
   endfunction

   function automatic logic [1:0] shift_ctrl(input logic dir);
      shift_ctrl = dir ? CTRL_SHR : CTRL_SHL;
   endfunction

   assign accept = (state_q == ST_IDLE) && cmd_valid && ready_q;

   // ctrl/done are computed one state ahead so every output leaves a flop.
   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ctrl_d  = CTRL_HOLD;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            if (accept) begin
               data_d  = cmd_data;
               dir_d   = cmd_dir;
               cnt_d   = sat_count(cmd_count);
               ready_d = 1'b0;
               busy_d  = 1'b1;
               ctrl_d  = CTRL_LOAD;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (cnt_q == '0) begin
               ctrl_d  = CTRL_HOLD;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               ctrl_d  = shift_ctrl(dir_q);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               ctrl_d  = CTRL_HOLD;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ctrl_q  <= CTRL_HOLD;
         data_q  <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      dir_q <= dir_d;
      cnt_q <= cnt_d;
   end

   assign cmd_ready = ready_q;
   assign ctrl      = ctrl_q;
   assign data      = data_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef SHIFT_SEQ_SHADOW_EN
   shift_seq_shadow #(
      .WIDTH(WIDTH)
   ) u_shadow (
      .clk      (clk),
      .reset    (reset),
      .ctrl     (ctrl_q),
      .data     (data_q),
      .q_reg    (q_reg),
      .chk      (done_q),
      .clr      (accept),
      .mismatch (mismatch)
   );
`else
   logic unused_q_reg;
   assign unused_q_reg = ^q_reg;
   assign mismatch     = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: drives commands, models the downstream register,
// and checks each command against its arithmetic end result and timing.
module tb_shift_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_dir = 1'b0;
   logic [3:0] cmd_count = 4'h0;
   logic [1:0] ctrl;
   logic [7:0] data;
   logic [7:0] q_reg;
   logic       busy;
   logic       done;
   logic       mismatch;

   logic [7:0] sr = 8'h00;
   logic       force_en = 1'b0;
   logic [7:0] force_val = 8'h00;

   int checks = 0;
   int errors = 0;

   shift_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_dir   (cmd_dir),
      .cmd_count (cmd_count),
      .ctrl      (ctrl),
      .data      (data),
      .q_reg     (q_reg),
      .busy      (busy),
      .done      (done),
      .mismatch  (mismatch)
   );

   always #5 clk = ~clk;

   // Downstream shift register the sequencer is driving.
   always @(posedge clk) begin
      case (ctrl)
         2'b01:   sr <= {sr[6:0], 1'b0};
         2'b10:   sr <= {1'b0, sr[7:1]};
         2'b11:   sr <= data;
         default: sr <= sr;
      endcase
   end

   assign q_reg = force_en ? force_val : sr;

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   // Issues one command and checks every cycle through the first idle cycle.
   // Entered and left just after a falling edge.
   task automatic run_cmd(input logic [7:0] d, input logic dir, input logic [3:0] c,
                          input bit keep = 1'b0, input logic [7:0] nd = 8'h00,
                          input logic ndir = 1'b0, input logic [3:0] nc = 4'h0);
      int n, k;
      logic [7:0]  expq;
      logic [1:0]  expc, shc;
      logic [13:0] got, exp;
      n    = (c > 4'd8) ? 8 : int'(c);
      expq = dir ? (d >> n) : (d << n);
      shc  = dir ? 2'b10 : 2'b01;
      cmd_data  = d;
      cmd_dir   = dir;
      cmd_count = c;
      cmd_valid = 1'b1;
      k = 0;
      while (cmd_ready !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_wait cmd_ready=%b required 1", cmd_ready);
         cmd_valid = 1'b0;
         return;
      end
      @(negedge clk);
      if (keep) begin
         cmd_data  = nd;
         cmd_dir   = ndir;
         cmd_count = nc;
      end else begin
         cmd_valid = 1'b0;
      end
      for (int j = 1; j <= n + 2; j++) begin
         if (j > 1) @(negedge clk);
         expc = (j == 1) ? 2'b11 : (j == n + 2) ? 2'b00 : shc;
         got  = {ctrl, busy, done, cmd_ready, mismatch, data};
         exp  = {expc, 1'b1, (j == n + 2), 1'b0, 1'b0, d};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL cmd_cycle d=%h dir=%b cnt=%0d cyc=%0d {ctrl,busy,done,rdy,mm,data} got %h required %h",
                     d, dir, c, j, got, exp);
         end
      end
      checks++;
      if (q_reg !== expq) begin
         errors++;
         $display("FAIL q_final d=%h dir=%b cnt=%0d got %h required %h", d, dir, c, q_reg, expq);
      end
      @(negedge clk);
      got = {ctrl, busy, done, cmd_ready, mismatch, data};
      exp = {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, d};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL post_idle d=%h cnt=%0d got %h required %h", d, c, got, exp);
      end
   endtask

   task automatic test_reset();
      logic [13:0] got;
      #2 reset = 1'b1;
      @(negedge clk);
      got = {ctrl, busy, done, cmd_ready, mismatch, data};
      checks++;
      if (got !== 14'h0) begin
         errors++;
         $display("FAIL reset_values got %h required 0000", got);
      end
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge got %b required 0", cmd_ready);
      end
      @(negedge clk);
      got = {ctrl, busy, done, cmd_ready, mismatch, data};
      checks++;
      if (got !== 14'b00_0_0_1_0_00000000) begin
         errors++;
         $display("FAIL ready_after_edge got %h required %h", got, 14'b00_0_0_1_0_00000000);
      end
   endtask

   task automatic test_single();
      run_cmd(8'h81, 1'b0, 4'd1);
   endtask

   task automatic test_right();
      run_cmd(8'hF0, 1'b1, 4'd4);
   endtask

   task automatic test_count0();
      run_cmd(8'h5A, 1'b0, 4'd0);
   endtask

   task automatic test_saturate();
      run_cmd(8'hFF, 1'b0, 4'd15);
      run_cmd(8'hC3, 1'b1, 4'd9);
   endtask

   task automatic test_back_to_back();
      run_cmd(8'h3C, 1'b1, 4'd2, 1'b1, 8'hA7, 1'b0, 4'd3);
      run_cmd(8'hA7, 1'b0, 4'd3);
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       dir;
      logic [3:0] c;
      int         gap;
      for (int i = 0; i < 24; i++) begin
         d   = 8'($urandom);
         dir = 1'($urandom);
         c   = 4'($urandom_range(0, 15));
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) @(negedge clk);
         run_cmd(d, dir, c);
      end
   endtask

   task automatic test_reset_mid();
      logic [13:0] got;
      cmd_data  = 8'hA5;
      cmd_dir   = 1'b0;
      cmd_count = 4'd5;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      got = {ctrl, busy, done, cmd_ready, mismatch, data};
      checks++;
      if (got !== 14'h0) begin
         errors++;
         $display("FAIL reset_mid_immediate got %h required 0000", got);
      end
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({done, busy, cmd_ready} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_held {done,busy,rdy} got %b required 000", {done, busy, cmd_ready});
      end
      @(negedge clk);
      got = {ctrl, busy, done, cmd_ready, mismatch, data};
      checks++;
      if (got !== 14'b00_0_0_1_0_00000000) begin
         errors++;
         $display("FAIL reset_mid_release got %h required %h", got, 14'b00_0_0_1_0_00000000);
      end
      run_cmd(8'h6E, 1'b1, 4'd3);
   endtask

`ifdef SHIFT_SEQ_SHADOW_EN
   task automatic test_shadow();
      logic [7:0] d;
      int k;
      d = 8'($urandom);
      cmd_data  = d;
      cmd_dir   = 1'b1;
      cmd_count = 4'd3;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      k = 0;
      while (done !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL shadow_done_wait done=%b required 1", done);
         return;
      end
      force_val = (d >> 3) ^ 8'h10;
      force_en  = 1'b1;
      checks++;
      if (mismatch !== 1'b0) begin
         errors++;
         $display("FAIL shadow_in_done mismatch=%b required 0", mismatch);
      end
      @(negedge clk);
      force_en = 1'b0;
      checks++;
      if (mismatch !== 1'b1) begin
         errors++;
         $display("FAIL shadow_set mismatch=%b required 1", mismatch);
      end
      @(negedge clk);
      checks++;
      if (mismatch !== 1'b1) begin
         errors++;
         $display("FAIL shadow_sticky mismatch=%b required 1", mismatch);
      end
      run_cmd(8'h99, 1'b0, 4'd2);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_right();
      test_count0();
      test_saturate();
      test_back_to_back();
      test_random();
      test_reset_mid();
`ifdef SHIFT_SEQ_SHADOW_EN
      test_shadow();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
